// File: rtl/sng_pkg.sv
`default_nettype none
// =============================================================================
// sng_pkg : shared FSM state type and helpers for the et_sng stream generator
// Revision: 1.0
// =============================================================================
package sng_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sng_state_t;

    localparam int MAXW = 32;

    // Mirror the whole word, then shift the reversed low-p field back down.
    function automatic logic [MAXW-1:0] bitrev(input logic [MAXW-1:0] val, input int p);
        logic [MAXW-1:0] r;
        r = {<<{val}};
        return r >> (MAXW - p);
    endfunction

    function automatic int eff_prec(input int prec, input int w);
        return (prec == 0 || prec > w) ? w : prec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/et_cascade_ctr.sv
`default_nettype none
// =============================================================================
// et_cascade_ctr : G runtime-width group counters cascaded into an NC-bit stage
// Revision: 1.0
// =============================================================================
module et_cascade_ctr import sng_pkg::*; #(
    parameter int W   = 8,
    parameter int G   = 2,
    parameter int NC  = 1,
    parameter int PW  = $clog2(W + 1),
    parameter int NCW = (NC > 0) ? NC : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  inc,
    input  logic [PW-1:0]         p,
    output logic [G-1:0][W-1:0]   grp,
    output logic [NCW-1:0]        ncs,
    output logic                  all_max
);

    logic [W-1:0] w_max;
    logic [G-1:0] w_carry;
    logic         w_nc_inc;

    assign w_max = ~({W{1'b1}} << p);

    // Ripple carry: a stage advances only when every lower stage is at max.
    always_comb begin
        logic v_run;
        logic v_all;
        w_carry = '0;
        v_run   = inc;
        v_all   = 1'b1;
        for (int k = 0; k < G; k++) begin
            w_carry[k] = v_run;
            v_run      = v_run & (grp[k] == w_max);
            v_all      = v_all & (grp[k] == w_max);
        end
        w_nc_inc = v_run;
        all_max  = v_all & ((NC == 0) || (&ncs));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp <= '0;
            ncs <= '0;
        end else if (clr) begin
            grp <= '0;
            ncs <= '0;
        end else begin
            for (int k = 0; k < G; k++) begin
                if (w_carry[k]) begin
                    grp[k] <= (grp[k] == w_max) ? '0 : grp[k] + 1'b1;
                end
            end
            if (NC > 0 && w_nc_inc) begin
                ncs <= ncs + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/et_sng.sv
`default_nettype none
// =============================================================================
// et_sng : multi-channel counter-based stochastic number generator, early term.
// Revision: 1.0
// =============================================================================
module et_sng import sng_pkg::*; #(
    parameter int W   = 8,
    parameter int N   = 2,
    parameter int G   = 2,
    parameter int NC  = 1,
    parameter int REV = 0,
    parameter int PW  = $clog2(W + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [PW-1:0]            prec,
    input  logic [N-1:0][W-1:0]      Bxs,
    input  logic                     en,
    input  logic                     abort,
    output logic [N-1:0]             Xs,
    output logic [(NC>0?NC:1)-1:0]   Xcs,
    output logic                     valid,
    output logic                     busy,
    output logic                     done
);

    localparam int NCW = (NC > 0) ? NC : 1;

    sng_state_t              r_state;
    logic [N-1:0][W-1:0]     r_bx;
    logic [PW-1:0]           r_p;
    logic                    w_clr;
    logic [G-1:0][W-1:0]     w_grp;
    logic [NCW-1:0]          w_ncs;
    logic                    w_all_max;
    logic [PW-1:0]           w_sh;

    assign w_clr = (r_state == IDLE) & start & ~abort;
    assign valid = (r_state == RUN) & en;
    assign busy  = (r_state != IDLE);
    assign done  = valid & w_all_max;
    assign w_sh  = PW'(W) - r_p;
    assign Xcs   = (NC > 0 && valid) ? w_ncs : '0;

    et_cascade_ctr #(
        .W  (W),
        .G  (G),
        .NC (NC),
        .PW (PW)
    ) u_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_clr),
        .inc     (valid),
        .p       (r_p),
        .grp     (w_grp),
        .ncs     (w_ncs),
        .all_max (w_all_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_bx    <= '0;
            r_p     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && !abort) begin
                        r_state <= RUN;
                        r_bx    <= Bxs;
                        r_p     <= PW'(eff_prec(int'(prec), W));
                    end
                end
                RUN: begin
                    if (abort || done) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Left-aligning the p-bit field makes low precisions truncate Bx upward.
    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [W-1:0] w_f;
        logic [W-1:0] w_v;
        assign w_f   = (REV != 0) ? W'(bitrev(MAXW'(w_grp[i % G]), int'(r_p))) : w_grp[i % G];
        assign w_v   = w_f << w_sh;
        assign Xs[i] = valid & (w_v < r_bx[i]);
    end

endmodule
`default_nettype wire

// File: tb/tb_et_sng.sv
`default_nettype none
// =============================================================================
// tb_et_sng : scoreboard bench for et_sng (two configurations side by side)
// Revision: 1.0
// =============================================================================
module tb_et_sng;

    typedef struct packed {
        logic [1:0] xs;
        logic       xc;
        logic       dn;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    // unit 0: W=4 G=2 NC=1 REV=0 ; unit 1: W=3 G=1 NC=1 REV=1
    logic            s0, en0, ab0, v0, b0, d0;
    logic [2:0]      pr0;
    logic [1:0][3:0] bx0;
    logic [1:0]      xs0;
    logic [0:0]      xc0;
    logic            s1, en1, ab1, v1, b1, d1;
    logic [1:0]      pr1;
    logic [1:0][2:0] bx1;
    logic [1:0]      xs1;
    logic [0:0]      xc1;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;
    int   nbits[2];
    int   ndone[2];
    int   nones[2][2];
    logic prev_done[2];

    always #5 clk = ~clk;

    et_sng #(.W(4), .N(2), .G(2), .NC(1), .REV(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(s0), .prec(pr0), .Bxs(bx0), .en(en0),
        .abort(ab0), .Xs(xs0), .Xcs(xc0), .valid(v0), .busy(b0), .done(d0)
    );

    et_sng #(.W(3), .N(2), .G(1), .NC(1), .REV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1), .prec(pr1), .Bxs(bx1), .en(en1),
        .abort(ab1), .Xs(xs1), .Xcs(xc1), .valid(v1), .busy(b1), .done(d1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rev_bits(input int val, input int p);
        int r;
        r = 0;
        for (int i = 0; i < p; i++)
            if (((val >> i) & 1) != 0) r |= 1 << (p - 1 - i);
        return r;
    endfunction

    function automatic int eff(input int p, input int w);
        return (p == 0 || p > w) ? w : p;
    endfunction

    // Stream bit t: group j holds digit j of t in base 2^p, the NC stage the rest.
    task automatic push_run(input int u, input int p, input int b0v, input int b1v);
        int   w, g, pe, len, f;
        int   bx[2];
        exp_t e;
        w  = (u != 0) ? 3 : 4;
        g  = (u != 0) ? 1 : 2;
        pe = eff(p, w);
        len = 1 << (pe * g + 1);
        bx[0] = b0v;
        bx[1] = b1v;
        for (int t = 0; t < len; t++) begin
            for (int i = 0; i < 2; i++) begin
                f = (t >> (pe * (i % g))) % (1 << pe);
                if (u != 0) f = rev_bits(f, pe);
                e.xs[i] = (f << (w - pe)) < bx[i];
            end
            e.xc = ((t >> (pe * g)) & 1) != 0;
            e.dn = (t == len - 1);
            if (u != 0) q1.push_back(e);
            else        q0.push_back(e);
        end
    endtask

    task automatic launch(input int u, input int p, input int b0v, input int b1v);
        @(posedge clk);
        #1;
        if (u == 0) begin
            s0 = 1'b1; pr0 = 3'(p); bx0[0] = 4'(b0v); bx0[1] = 4'(b1v); en0 = 1'b1;
        end else begin
            s1 = 1'b1; pr1 = 2'(p); bx1[0] = 3'(b0v); bx1[1] = 3'(b1v); en1 = 1'b1;
        end
        nbits[u] = 0;
        ndone[u] = 0;
        nones[u][0] = 0;
        nones[u][1] = 0;
        push_run(u, p, b0v, b1v);
        @(posedge clk);
        #1;
        s0 = 1'b0;
        s1 = 1'b0;
    endtask

    // mode 0: en held high, 1: en toggles every cycle, 2: en random (75% high)
    task automatic finish_run(input int u, input int mode, input int budget);
        int   n;
        logic e;
        n = 0;
        while (((u != 0) ? b1 : b0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            e = (u != 0) ? en1 : en0;
            if (mode == 1)      e = ~e;
            else if (mode == 2) e = ($urandom_range(0, 3) != 0);
            if (u != 0) en1 = e;
            else        en0 = e;
        end
        chk("run_finished", (u != 0) ? b1 : b0, 0);
        en0 = 1'b1;
        en1 = 1'b1;
    endtask

    task automatic check_counts(input int u, input string tag, input int p,
                                input int b0v, input int b1v);
        int w, g, pe, sc, rep;
        w   = (u != 0) ? 3 : 4;
        g   = (u != 0) ? 1 : 2;
        pe  = eff(p, w);
        sc  = 1 << (w - pe);
        rep = 1 << (pe * (g - 1) + 1);
        chk({tag, "_len"},   nbits[u], 1 << (pe * g + 1));
        chk({tag, "_done"},  ndone[u], 1);
        chk({tag, "_ones0"}, nones[u][0], rep * ((b0v + sc - 1) / sc));
        chk({tag, "_ones1"}, nones[u][1], rep * ((b1v + sc - 1) / sc));
        chk({tag, "_left"},  (u != 0) ? q1.size() : q0.size(), 0);
    endtask

    task automatic mon(input int u, input logic v, input logic bz, input logic dn,
                       input logic [1:0] xs, input logic xc, input logic en);
        exp_t e;
        if (!rst_n) begin
            prev_done[u] = 1'b0;
            return;
        end
        if (prev_done[u]) chk("busy_after_done", bz, 0);
        prev_done[u] = dn;
        chk("valid", v, bz & en);
        if (v) begin
            nbits[u]++;
            ndone[u]    += int'(dn);
            nones[u][0] += int'(xs[0]);
            nones[u][1] += int'(xs[1]);
            if (((u != 0) ? q1.size() : q0.size()) == 0) begin
                total++;
                bad++;
                $display("FAIL extra_bit: unit %0d got a bit with no expectation at %0t", u, $time);
            end else begin
                if (u != 0) e = q1.pop_front();
                else        e = q0.pop_front();
                chk("xs",   xs, e.xs);
                chk("xcs",  xc, e.xc);
                chk("done", dn, e.dn);
                if (u != 0) chk("xs_corr", xs[0], xs[1]);
            end
        end else begin
            chk("stall_zero", {xs, xc, dn}, 0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, v0, b0, d0, xs0, xc0[0], en0);
        mon(1, v1, b1, d1, xs1, xc1[0], en1);
    end

    initial begin
        int p, a, b, m;
        rst_n = 1'b0;
        s0 = 1'b0; en0 = 1'b1; ab0 = 1'b0; pr0 = '0; bx0 = '0;
        s1 = 1'b0; en1 = 1'b1; ab1 = 1'b0; pr1 = '0; bx1 = '0;
        prev_done[0] = 1'b0;
        prev_done[1] = 1'b0;
        #12;
        chk("reset_out0", {v0, b0, d0, xs0, xc0}, 0);
        chk("reset_out1", {v1, b1, d1, xs1, xc1}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        launch(0, 4, 8, 4);   finish_run(0, 0, 1000); check_counts(0, "full_p4", 4, 8, 4);
        launch(0, 2, 8, 5);   finish_run(0, 0, 200);  check_counts(0, "p2", 2, 8, 5);
        launch(1, 3, 4, 4);   finish_run(1, 0, 200);  check_counts(1, "rev_g1", 3, 4, 4);
        launch(0, 2, 8, 5);   finish_run(0, 1, 400);  check_counts(0, "stall", 2, 8, 5);
        launch(0, 4, 0, 15);  finish_run(0, 0, 1000); check_counts(0, "extremes", 4, 0, 15);

        // abort while bit 10 is on the outputs
        launch(0, 4, 9, 3);
        repeat (9) @(posedge clk);
        #1 ab0 = 1'b1;
        @(posedge clk);
        #1 ab0 = 1'b0;
        q0.delete();
        chk("abort_idle",   b0, 0);
        chk("abort_bits",   nbits[0], 10);
        chk("abort_nodone", ndone[0], 0);
        launch(0, 1, 2, 13);  finish_run(0, 0, 100);  check_counts(0, "after_abort", 1, 2, 13);

        // asynchronous reset between clock edges
        launch(0, 3, 5, 11);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("async_rst_out", {v0, b0, d0, xs0, xc0}, 0);
        q0.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // prec=0 means full precision; a start pulse mid-run must be ignored
        launch(0, 0, 7, 12);
        repeat (20) @(posedge clk);
        #1 s0 = 1'b1; pr0 = 3'd1; bx0[0] = 4'd15; bx0[1] = 4'd0;
        @(posedge clk);
        #1 s0 = 1'b0;
        finish_run(0, 0, 1000); check_counts(0, "prec0", 0, 7, 12);

        for (int r = 0; r < 6; r++) begin
            p = $urandom_range(1, 3);
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 15);
            m = $urandom_range(0, 2);
            launch(0, p, a, b); finish_run(0, m, 2000); check_counts(0, "rnd0", p, a, b);
        end
        for (int r = 0; r < 3; r++) begin
            p = $urandom_range(1, 3);
            a = $urandom_range(0, 7);
            m = $urandom_range(0, 2);
            launch(1, p, a, a); finish_run(1, m, 500); check_counts(1, "rnd1", p, a, a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
